// File: rtl/keypad_pkg.sv
// Shared definitions for the keypad number-entry block: key codes, key map,
// debounce state encoding and datapath widths.
package keypad_pkg;

    localparam int unsigned ROWS       = 4;
    localparam int unsigned COLS       = 4;
    localparam int unsigned KEY_W      = 4;
    localparam int unsigned KEYS       = ROWS * COLS;
    localparam int unsigned HIT_W      = 5;
    localparam int unsigned BCD_W      = 16;
    localparam int unsigned NUM_W      = 16;
    localparam int unsigned NUM_SIG_W  = 14;
    localparam int unsigned MAX_DIGITS = 4;
    localparam int unsigned DCNT_W     = 3;

    localparam logic [KEY_W-1:0] KEY_CLEAR = 4'hE;
    localparam logic [KEY_W-1:0] KEY_ENTER = 4'hF;

    // Indexed by {row, col}; element 0 is row 0 / column 0.
    //   r0: 1 2 3 A   r1: 4 5 6 B   r2: 7 8 9 C   r3: * 0 # D
    localparam logic [KEYS-1:0][KEY_W-1:0] KEY_MAP = 64'hDF0E_C987_B654_A321;

    typedef enum logic [1:0] {
        DEB_IDLE       = 2'd0,
        DEB_PRESS_WAIT = 2'd1,
        DEB_HELD       = 2'd2
    } deb_state_t;

    function automatic logic [KEY_W-1:0] key_lookup(input logic [3:0] pos);
        return KEY_MAP[pos];
    endfunction

    function automatic logic is_digit(input logic [KEY_W-1:0] code);
        return code <= 4'd9;
    endfunction

endpackage

// File: rtl/keypad_number_entry_if.sv
// Keypad matrix lines plus the decoded-key and number-entry results.
interface keypad_number_entry_if;
    import keypad_pkg::*;

    logic [ROWS-1:0]  row;
    logic [COLS-1:0]  col;
    logic [KEY_W-1:0] key_code;
    logic             key_strobe;
    logic [BCD_W-1:0] digits;
    logic [NUM_W-1:0] number;
    logic             valid;

    modport master (
        output row,
        input  col, key_code, key_strobe, digits, number, valid
    );

    modport slave (
        input  row,
        output col, key_code, key_strobe, digits, number, valid
    );

endinterface

// File: rtl/keypad_scanner.sv
// Column scanner: drives one active-low column per dwell, synchronises the rows
// and classifies each complete 16-key snapshot into a single-key candidate.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int unsigned SCAN_DIV = 17
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [ROWS-1:0]  row,
    output logic [COLS-1:0]  col,
    output logic [KEY_W-1:0] candidate,
    output logic             candidate_valid,
    output logic             scan_done
);

    logic [SCAN_DIV-1:0] div;
    logic [1:0]          col_idx;
    logic [1:0]          col_next_c;
    logic                dwell_end_c;
    logic [ROWS-1:0]     row_meta;
    logic [ROWS-1:0]     row_sync;
    logic [KEYS-1:0]     snap;
    logic [KEYS-1:0]     snap_c;
    logic [KEY_W-1:0]    cand_c;
    logic                cand_valid_c;
    logic [HIT_W-1:0]    hits_c;

    assign dwell_end_c = &div;
    assign col_next_c  = col_idx + 2'd1;

    // Merge the rows seen on the current column into the snapshot.
    always_comb begin
        snap_c = snap;
        for (int r = 0; r < int'(ROWS); r++) begin
            snap_c[{2'(r), col_idx}] = ~row_sync[r];
        end
    end

    // Exactly one pressed key yields a candidate; ghosting or no key does not.
    always_comb begin
        hits_c = '0;
        cand_c = '0;
        for (int i = 0; i < int'(KEYS); i++) begin
            if (snap_c[i]) begin
                hits_c = hits_c + 5'd1;
                cand_c = key_lookup(4'(i));
            end
        end
        cand_valid_c = (hits_c == 5'd1);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            div             <= '0;
            col_idx         <= '0;
            col             <= 4'b1110;
            row_meta        <= 4'hF;
            row_sync        <= 4'hF;
            snap            <= '0;
            candidate       <= '0;
            candidate_valid <= 1'b0;
            scan_done       <= 1'b0;
        end else begin
            row_meta  <= row;
            row_sync  <= row_meta;
            div       <= div + SCAN_DIV'(1);
            scan_done <= 1'b0;
            if (dwell_end_c) begin
                snap    <= snap_c;
                col_idx <= col_next_c;
                col     <= ~(4'b0001 << col_next_c);
                if (col_idx == 2'd3) begin
                    candidate       <= cand_valid_c ? cand_c : '0;
                    candidate_valid <= cand_valid_c;
                    scan_done       <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/keypad_number_entry.sv
// Keypad number entry: debounces scanner candidates into key strobes and
// accumulates up to four decimal digits as BCD and binary, with clear/enter.
module keypad_number_entry
    import keypad_pkg::*;
#(
    parameter int unsigned SCAN_DIV       = 17,
    parameter int unsigned DEBOUNCE_SCANS = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    keypad_number_entry_if.slave bus
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_SCANS + 1);

    logic [KEY_W-1:0]     cand;
    logic                 cand_valid;
    logic                 scan_done;

    deb_state_t           state, state_n;
    logic [CNT_W-1:0]     cnt, cnt_n, cnt_inc_c;
    logic [KEY_W-1:0]     pend, pend_n;
    logic                 strobe_c;

    logic [NUM_SIG_W-1:0] num_sig;
    logic [DCNT_W-1:0]    dcount;
    logic                 after_enter;

    keypad_scanner #(
        .SCAN_DIV (SCAN_DIV)
    ) u_scanner (
        .clk             (clk),
        .rst_n           (rst_n),
        .row             (bus.row),
        .col             (bus.col),
        .candidate       (cand),
        .candidate_valid (cand_valid),
        .scan_done       (scan_done)
    );

    assign cnt_inc_c = cnt + CNT_W'(1);

    // Debounce next-state: evaluated once per completed scan.
    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        pend_n   = pend;
        strobe_c = 1'b0;
        if (scan_done) begin
            unique case (state)
                DEB_IDLE: begin
                    if (cand_valid) begin
                        pend_n = cand;
                        if (DEBOUNCE_SCANS <= 1) begin
                            state_n  = DEB_HELD;
                            cnt_n    = '0;
                            strobe_c = 1'b1;
                        end else begin
                            state_n = DEB_PRESS_WAIT;
                            cnt_n   = CNT_W'(1);
                        end
                    end
                end
                DEB_PRESS_WAIT: begin
                    if (cand_valid && (cand == pend)) begin
                        if (cnt_inc_c >= CNT_W'(DEBOUNCE_SCANS)) begin
                            state_n  = DEB_HELD;
                            cnt_n    = '0;
                            strobe_c = 1'b1;
                        end else begin
                            cnt_n = cnt_inc_c;
                        end
                    end else begin
                        state_n = DEB_IDLE;
                        cnt_n   = '0;
                    end
                end
                DEB_HELD: begin
                    // Only consecutive empty scans count towards release.
                    if (!cand_valid) begin
                        if (cnt_inc_c >= CNT_W'(DEBOUNCE_SCANS)) begin
                            state_n = DEB_IDLE;
                            cnt_n   = '0;
                        end else begin
                            cnt_n = cnt_inc_c;
                        end
                    end else begin
                        cnt_n = '0;
                    end
                end
                default: begin
                    state_n = DEB_IDLE;
                    cnt_n   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state          <= DEB_IDLE;
            cnt            <= '0;
            pend           <= '0;
            bus.key_strobe <= 1'b0;
            bus.key_code   <= '0;
        end else begin
            state          <= state_n;
            cnt            <= cnt_n;
            pend           <= pend_n;
            bus.key_strobe <= strobe_c;
            if (strobe_c) begin
                bus.key_code <= pend_n;
            end
        end
    end

    // Entry datapath reacts to the registered strobe, one cycle after it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bus.digits  <= '0;
            num_sig     <= '0;
            dcount      <= '0;
            after_enter <= 1'b0;
            bus.valid   <= 1'b0;
        end else begin
            bus.valid <= 1'b0;
            if (bus.key_strobe) begin
                if (is_digit(bus.key_code)) begin
                    if (after_enter) begin
                        bus.digits  <= {12'h000, bus.key_code};
                        num_sig     <= NUM_SIG_W'(bus.key_code);
                        dcount      <= DCNT_W'(1);
                        after_enter <= 1'b0;
                    end else if (dcount < DCNT_W'(MAX_DIGITS)) begin
                        bus.digits <= {bus.digits[11:0], bus.key_code};
                        num_sig    <= num_sig * NUM_SIG_W'(10) + NUM_SIG_W'(bus.key_code);
                        dcount     <= dcount + DCNT_W'(1);
                    end
                end else if (bus.key_code == KEY_CLEAR) begin
                    bus.digits  <= '0;
                    num_sig     <= '0;
                    dcount      <= '0;
                    after_enter <= 1'b0;
                end else if (bus.key_code == KEY_ENTER) begin
                    bus.valid   <= 1'b1;
                    after_enter <= 1'b1;
                end
            end
        end
    end

    assign bus.number = NUM_W'(num_sig);

endmodule

// File: tb/tb_keypad_number_entry.sv
// Directed bench for keypad_number_entry with a behavioural 4x4 key matrix.
module tb_keypad_number_entry;

    logic        clk;
    logic        rst_n;
    logic [15:0] keys;
    logic [3:0]  row_drive;
    int          n_cmp;
    int          n_fail;
    int          strobe_cnt;
    int          valid_cnt;

    keypad_number_entry_if bus();

    keypad_number_entry #(
        .SCAN_DIV       (2),
        .DEBOUNCE_SCANS (2)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pressed key at [r][c] pulls row r low while column c is driven low.
    always_comb begin
        row_drive = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (keys[r*4+c] && !bus.col[c]) row_drive[r] = 1'b0;
    end
    assign bus.row = row_drive;

    always @(negedge clk) begin
        if (bus.key_strobe === 1'b1) strobe_cnt++;
        if (bus.valid === 1'b1) valid_cnt++;
    end

    typedef struct {
        logic [3:0]  key;
        logic [15:0] digits;
        logic [15:0] number;
        int          valid_inc;
    } vec_t;

    vec_t vecs [19];

    function automatic int key_pos(input logic [3:0] k);
        case (k)
            4'h1: return 0;   4'h2: return 1;   4'h3: return 2;   4'hA: return 3;
            4'h4: return 4;   4'h5: return 5;   4'h6: return 6;   4'hB: return 7;
            4'h7: return 8;   4'h8: return 9;   4'h9: return 10;  4'hC: return 11;
            4'hE: return 12;  4'h0: return 13;  4'hF: return 14;  default: return 15;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic press(input logic [3:0] k, input int hold, input int rel);
        keys = 16'h0001 << key_pos(k);
        repeat (hold * 16) @(negedge clk);
        keys = 16'h0000;
        repeat (rel * 16) @(negedge clk);
    endtask

    task automatic wait_scan_start();
        logic [3:0] prev;
        bit found;
        found = 1'b0;
        prev  = bus.col;
        for (int k = 0; k < 64 && !found; k++) begin
            @(negedge clk);
            if (bus.col == 4'b1110 && prev != 4'b1110) found = 1'b1;
            prev = bus.col;
        end
        check("scan_start_seen", 32'(found), 32'd1);
    endtask

    task automatic wait_strobe(input int budget, output bit found);
        found = 1'b0;
        for (int k = 0; k < budget && !found; k++) begin
            @(negedge clk);
            if (bus.key_strobe === 1'b1) found = 1'b1;
        end
    endtask

    initial begin
        int s0, v0;
        bit found;
        n_cmp = 0; n_fail = 0; strobe_cnt = 0; valid_cnt = 0;
        keys  = 16'h0000;
        rst_n = 1'b0;

        vecs[0]  = '{4'h4, 16'h0004, 16'd4,    0};
        vecs[1]  = '{4'h0, 16'h0040, 16'd40,   0};
        vecs[2]  = '{4'h9, 16'h0409, 16'd409,  0};
        vecs[3]  = '{4'h2, 16'h4092, 16'd4092, 0};
        vecs[4]  = '{4'hF, 16'h4092, 16'd4092, 1};
        vecs[5]  = '{4'h1, 16'h0001, 16'd1,    0};
        vecs[6]  = '{4'h2, 16'h0012, 16'd12,   0};
        vecs[7]  = '{4'h3, 16'h0123, 16'd123,  0};
        vecs[8]  = '{4'h4, 16'h1234, 16'd1234, 0};
        vecs[9]  = '{4'h5, 16'h1234, 16'd1234, 0};
        vecs[10] = '{4'hE, 16'h0000, 16'd0,    0};
        vecs[11] = '{4'hA, 16'h0000, 16'd0,    0};
        vecs[12] = '{4'hF, 16'h0000, 16'd0,    1};
        vecs[13] = '{4'h9, 16'h0009, 16'd9,    0};
        vecs[14] = '{4'h9, 16'h0099, 16'd99,   0};
        vecs[15] = '{4'h9, 16'h0999, 16'd999,  0};
        vecs[16] = '{4'h9, 16'h9999, 16'd9999, 0};
        vecs[17] = '{4'h8, 16'h9999, 16'd9999, 0};
        vecs[18] = '{4'hE, 16'h0000, 16'd0,    0};

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_col",    32'(bus.col),        32'h0000000E);
        check("rst_code",   32'(bus.key_code),   32'd0);
        check("rst_strobe", 32'(bus.key_strobe), 32'd0);
        check("rst_digits", 32'(bus.digits),     32'd0);
        check("rst_number", 32'(bus.number),     32'd0);
        check("rst_valid",  32'(bus.valid),      32'd0);
        rst_n = 1'b1;

        // Table: each key held 4 scans, released 4 scans
        for (int i = 0; i < 19; i++) begin
            s0 = strobe_cnt;
            v0 = valid_cnt;
            press(vecs[i].key, 4, 4);
            check($sformatf("v%0d_strobes", i), 32'(strobe_cnt - s0), 32'd1);
            check($sformatf("v%0d_code", i),    32'(bus.key_code),    32'(vecs[i].key));
            check($sformatf("v%0d_digits", i),  32'(bus.digits),      32'(vecs[i].digits));
            check($sformatf("v%0d_number", i),  32'(bus.number),      32'(vecs[i].number));
            check($sformatf("v%0d_valid", i),   32'(valid_cnt - v0),  32'(vecs[i].valid_inc));
        end

        // Long hold of 7: single strobe, entry lags strobe by one cycle
        s0 = strobe_cnt;
        keys = 16'h0001 << key_pos(4'h7);
        wait_strobe(80, found);
        check("hold7_seen",        32'(found),        32'd1);
        check("hold7_code",        32'(bus.key_code), 32'd7);
        check("hold7_digits_lag",  32'(bus.digits),   32'd0);
        @(negedge clk);
        check("hold7_strobe_1cyc", 32'(bus.key_strobe), 32'd0);
        check("hold7_digits",      32'(bus.digits),     32'h0007);
        repeat (18 * 16) @(negedge clk);
        keys = 16'h0000;
        repeat (4 * 16) @(negedge clk);
        check("hold7_strobes", 32'(strobe_cnt - s0), 32'd1);
        v0 = valid_cnt;
        press(4'hF, 4, 4);
        check("hold7_enter_valid",  32'(valid_cnt - v0), 32'd1);
        check("hold7_enter_number", 32'(bus.number),     32'd7);
        press(4'h3, 4, 4);
        check("after_enter_number", 32'(bus.number), 32'd3);
        check("after_enter_digits", 32'(bus.digits), 32'h0003);

        // Key 5 bouncing on alternate scans, then stable
        s0 = strobe_cnt;
        for (int i = 0; i < 6; i++) begin
            wait_scan_start();
            keys = (i % 2 == 0) ? (16'h0001 << key_pos(4'h5)) : 16'h0000;
        end
        wait_scan_start();
        keys = 16'h0000;
        repeat (3 * 16) @(negedge clk);
        check("bounce_no_strobe", 32'(strobe_cnt - s0), 32'd0);
        press(4'h5, 4, 4);
        check("bounce_stable_strobes", 32'(strobe_cnt - s0), 32'd1);
        check("bounce_stable_code",    32'(bus.key_code),    32'd5);
        check("bounce_digits",         32'(bus.digits),      32'h0035);

        // Two keys at once: no candidate until one is released
        s0 = strobe_cnt;
        keys = (16'h0001 << key_pos(4'h1)) | (16'h0001 << key_pos(4'h2));
        repeat (4 * 16) @(negedge clk);
        check("dual_no_strobe", 32'(strobe_cnt - s0), 32'd0);
        keys = 16'h0001 << key_pos(4'h1);
        repeat (4 * 16) @(negedge clk);
        keys = 16'h0000;
        repeat (4 * 16) @(negedge clk);
        check("dual_release_strobes", 32'(strobe_cnt - s0), 32'd1);
        check("dual_release_code",    32'(bus.key_code),    32'd1);
        check("dual_number",          32'(bus.number),      32'd351);

        // Reset during PRESS_WAIT with the key still held
        wait_scan_start();
        keys = 16'h0001 << key_pos(4'h8);
        wait_scan_start();
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("midrst_col",    32'(bus.col),        32'h0000000E);
        check("midrst_code",   32'(bus.key_code),   32'd0);
        check("midrst_strobe", 32'(bus.key_strobe), 32'd0);
        check("midrst_digits", 32'(bus.digits),     32'd0);
        check("midrst_number", 32'(bus.number),     32'd0);
        check("midrst_valid",  32'(bus.valid),      32'd0);
        s0 = strobe_cnt;
        rst_n = 1'b1;
        repeat (24) @(negedge clk);
        check("midrst_no_early_strobe", 32'(strobe_cnt - s0), 32'd0);
        wait_strobe(40, found);
        check("midrst_fresh_strobe", 32'(found),        32'd1);
        check("midrst_fresh_code",   32'(bus.key_code), 32'd8);
        keys = 16'h0000;
        repeat (4 * 16) @(negedge clk);
        check("midrst_strobes", 32'(strobe_cnt - s0), 32'd1);
        check("midrst_digits_after", 32'(bus.digits), 32'h0008);
        check("midrst_number_after", 32'(bus.number), 32'd8);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/keypad_number_entry.md
KEYPAD_NUMBER_ENTRY -- requirements
Module: keypad_number_entry

Interface
REQ-001 Parameter SCAN_DIV, default 17: column dwell is 2^SCAN_DIV Clk cycles.
REQ-002 Parameter DEBOUNCE_SCANS, default 4: number of consecutive full scans needed for a stable press or release.
REQ-003 The block SHALL use one clock; reset is synchronous and active-low.
REQ-004 Clk  input  1  system clock, 100 MHz.
REQ-005 Rst_n  input  1  synchronous active-low reset.
REQ-006 Row  input  4  keypad rows, active-low, pulled up, asynchronous.
REQ-007 Col  output  4  keypad column drive, active-low one-hot.
REQ-008 KeyCode  output  4  code of the last debounced key.
REQ-009 KeyStrobe  output  1  one-cycle pulse for each debounced press.
REQ-010 Digits  output  16  four BCD digits of the entry, most recent digit in [3:0]; feeds the four-digit seven-segment display.
REQ-011 Number  output  16  binary value of the entry, 0..9999, zero-extended.
REQ-012 Valid  output  1  one-cycle pulse when the entry is committed.

Function
REQ-013 Key map by [row][col]: r0 = 1 2 3 A; r1 = 4 5 6 B; r2 = 7 8 9 C; r3 = * 0 #. The * key is code 4'hE (clear), # is 4'hF (enter), A to D are 4'hA to 4'hD.
REQ-014 A SCAN_DIV-bit divider SHALL advance the column index 0,1,2,3,0 on terminal count; Col = ~(1 << index).
REQ-015 Row SHALL pass through a 2-FF synchronizer and be sampled on the last cycle of each column dwell.
REQ-016 After column 3 is sampled, the 16-bit snapshot SHALL be classified: exactly one key means candidate = that code; zero or more than one key means no candidate.
REQ-017 Debounce FSM states:
- IDLE: a candidate moves to PRESS_WAIT with count = 1.
- PRESS_WAIT: the same candidate increments count, and reaching DEBOUNCE_SCANS moves to HELD. Any other classification moves to IDLE.
- HELD: DEBOUNCE_SCANS consecutive no-candidate scans move to IDLE. There is no auto-repeat.
REQ-018 On entry to HELD, KeyStrobe SHALL pulse for exactly one cycle, and KeyCode SHALL update in the same cycle and hold until the next strobe.
REQ-019 Digit key, digit count < 4: Digits <= {Digits[11:0], d}; Number <= Number*10 + d; count++. All of these update one cycle after KeyStrobe.
REQ-020 Digit key, count = 4: ignored; Digits, Number and count are unchanged.
REQ-021 Clear (4'hE): Digits, Number and count go to 0 one cycle after KeyStrobe.
REQ-022 Enter (4'hF): Valid pulses one cycle after KeyStrobe, and Number and Digits hold. The next digit key clears the entry before inserting, so the new entry equals that digit alone.
REQ-023 Enter with count = 0 SHALL still pulse Valid, with Number = 0.
REQ-024 Keys A to D SHALL produce KeyStrobe only and have no entry effect.
REQ-025 Number arithmetic uses 14 significant bits (max 9999) and SHALL never wrap.

Reset
REQ-026 While Rst_n = 0 at a Clk edge, the block SHALL set:
- Col = 4'b1110; divider, index and debounce count = 0; FSM = IDLE.
- KeyCode = 0, KeyStrobe = 0, Digits = 0, Number = 0, Valid = 0; digit count = 0; post-enter flag cleared.
REQ-027 Reset mid-debounce or mid-hold SHALL discard the pending key, with no strobe emitted for it after reset release.
REQ-028 Synchronizer flops SHALL reset to 4'b1111.

Structure
REQ-029 Shared package keypad_pkg SHALL hold:
- KEY_CLEAR = 4'hE, KEY_ENTER = 4'hF;
- the key-map table;
- the debounce FSM state encoding.
REQ-030 Sub-module keypad_scanner SHALL contain the divider, column drive, synchronizer and snapshot classification. It outputs candidate, candidate_valid and scan_done (one-cycle pulse).
REQ-031 Debounce FSM and entry datapath SHALL reside in keypad_number_entry.

Verification (SCAN_DIV = 2, DEBOUNCE_SCANS = 2 for all scenarios)
REQ-032 Press 4, 0, 9, 2, then #, each held 4 scans and released 4 scans -> Digits = 16'h4092, Number = 16'd4092, one Valid pulse, four KeyStrobes plus one for #.
REQ-033 Key 5 present on alternate scans only -> no KeyStrobe; then stable for 2 scans -> exactly one KeyStrobe with KeyCode = 5.
REQ-034 Keys 1 and 2 pressed together -> no KeyStrobe; release 2 -> one KeyStrobe with KeyCode = 1.
REQ-035 Press 1, 2, 3, 4, 5 -> Digits = 16'h1234, Number = 1234; then * -> Digits = 0, Number = 0.
REQ-036 Hold 7 for 20 scans -> exactly one KeyStrobe; then #, then 3 -> Number = 3, Digits = 16'h0003.
REQ-037 Assert Rst_n = 0 during PRESS_WAIT, release with the key still held -> all reset values, Col = 4'b1110, and the next strobe only after a fresh DEBOUNCE_SCANS.
